// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM encoding for the SPI-to-register-map bridge.
`timescale 1ns/1ps

package spi_reg_pkg;

    localparam int BYTE_BITS = 8;
    localparam int RW_BIT    = 7;
    localparam int BIT_CNT_W = $clog2(BYTE_BITS);

    // Plain sized constants keep the encoding visible to older tooling and waveforms.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_CMD      = 3'd1;
    localparam state_t ST_RD_WAIT  = 3'd2;
    localparam state_t ST_RD_SHIFT = 3'd3;
    localparam state_t ST_WR_SHIFT = 3'd4;
    localparam state_t ST_WR_PULSE = 3'd5;

    function automatic logic [BYTE_BITS-1:0] shift_in(input logic [BYTE_BITS-1:0] cur,
                                                      input logic                 bit_i);
        return {cur[BYTE_BITS-2:0], bit_i};
    endfunction

endpackage

// File: rtl/spi_reg_bridge_sync_edge_detect.sv
// N-stage synchronizer for one asynchronous input plus registered-level edge pulses.
`timescale 1ns/1ps

module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d  = (sync_q << 1) | STAGES'(sig_i);
        prev_d  = sync_q[STAGES-1];
        level_o = sync_q[STAGES-1];
        rise_o  = sync_q[STAGES-1] & ~prev_q;
        fall_o  = ~sync_q[STAGES-1] & prev_q;
    end

    // Clearing to 0 means a chip select already low through reset never looks like
    // a fresh falling edge; a spurious rise while idle is harmless.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave front-end that turns host frames into register-map reads and writes,
// with auto-incrementing bursts inside one chip-select frame.
`timescale 1ns/1ps

module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int READ_LAT    = 3,
    parameter int WR_HOLD     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  spi_sclk_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  write_en_o,
    output logic                  read_en_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    output logic                  busy_o
);

    localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
    localparam logic [LAT_W-1:0]     LAT_LAST  = LAT_W'(READ_LAT - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(WR_HOLD - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(BYTE_BITS - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_lvl;
    logic sclk_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i(clk_i), .rst_n(rst_n), .sig_i(spi_sclk_i),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk_i(clk_i), .rst_n(rst_n), .sig_i(spi_cs_n_i),
        .level_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i(clk_i), .rst_n(rst_n), .sig_i(spi_mosi_i),
        .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    state_t                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wen_q, wen_d;
    logic                  ren_q, ren_d;
    logic                  miso_q, miso_d;
    logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                  end_pend_q, end_pend_d;

    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  last_bit;

    always_comb begin
        // NOTE: every *_d starts from its *_q so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wen_d      = wen_q;
        ren_d      = ren_q;
        miso_d     = miso_q;
        lat_cnt_d  = lat_cnt_q;
        hold_cnt_d = hold_cnt_q;
        end_pend_d = end_pend_q;

        rx_byte  = shift_in(rx_q, mosi_lvl);
        last_bit = (bit_cnt_q == BIT_LAST);

        // Frame end outside a write pulse drops any partial byte immediately.
        if (cs_rise && state_q != ST_IDLE && state_q != ST_WR_PULSE) begin
            state_d = ST_IDLE;
            ren_d   = 1'b0;
            wen_d   = 1'b0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    ren_d  = 1'b0;
                    wen_d  = 1'b0;
                    if (cs_fall) begin
                        bit_cnt_d = '0;
                        rx_d      = '0;
                        state_d   = ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit) begin
                            addr_d = rx_byte[ADDR_WIDTH-1:0];
                            if (rx_byte[RW_BIT]) begin
                                ren_d     = 1'b1;
                                lat_cnt_d = '0;
                                state_d   = ST_RD_WAIT;
                            end else begin
                                state_d = ST_WR_SHIFT;
                            end
                        end
                    end
                end

                ST_RD_WAIT: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        tx_d      = read_data_i;
                        miso_d    = read_data_i[DATA_WIDTH-1];
                        bit_cnt_d = '0;
                        state_d   = ST_RD_SHIFT;
                    end else begin
                        lat_cnt_d = lat_cnt_q + LAT_W'(1);
                    end
                end

                ST_RD_SHIFT: begin
                    // The MSB is already on miso; falls before the first rise of the
                    // byte (the tail of the previous byte) must not shift.
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit) begin
                            addr_d    = addr_q + ADDR_WIDTH'(1);
                            lat_cnt_d = '0;
                            state_d   = ST_RD_WAIT;
                        end
                    end else if (sclk_fall && bit_cnt_q != '0) begin
                        tx_d   = tx_q << 1;
                        miso_d = tx_q[DATA_WIDTH-2];
                    end
                end

                ST_WR_SHIFT: begin
                    if (sclk_rise) begin
                        rx_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit) begin
                            wdata_d    = rx_byte;
                            wen_d      = 1'b1;
                            hold_cnt_d = '0;
                            end_pend_d = 1'b0;
                            state_d    = ST_WR_PULSE;
                        end
                    end
                end

                ST_WR_PULSE: begin
                    // A frame end here is remembered so the strobe always runs full length.
                    end_pend_d = end_pend_q | cs_rise;
                    if (hold_cnt_q == HOLD_LAST) begin
                        wen_d     = 1'b0;
                        addr_d    = addr_q + ADDR_WIDTH'(1);
                        bit_cnt_d = '0;
                        state_d   = (end_pend_q || cs_rise) ? ST_IDLE : ST_WR_SHIFT;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            miso_q     <= 1'b0;
            lat_cnt_q  <= '0;
            hold_cnt_q <= '0;
            end_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
            miso_q     <= miso_d;
            lat_cnt_q  <= lat_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            end_pend_q <= end_pend_d;
        end
    end

    assign spi_miso_o   = miso_q;
    assign addr_o       = addr_q;
    assign write_data_o = wdata_q;
    assign write_en_o   = wen_q;
    assign read_en_o    = ren_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: host-side SPI driver, a 2-cycle register-map read
// model and a write-strobe logger, with per-scenario tasks.
`timescale 1ns/1ps

module tb_spi_reg_bridge;

    localparam int HALF = 8;  // sclk half period in clk_i cycles (16x oversampling)

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [6:0] addr_o;
    logic [7:0] write_data_o;
    logic       write_en_o;
    logic       read_en_o;
    logic [7:0] read_data = 8'h00;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int model_sel = 0;

    always #5 clk_i = ~clk_i;

    spi_reg_bridge dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .spi_sclk_i(spi_sclk), .spi_cs_n_i(spi_cs_n), .spi_mosi_i(spi_mosi),
        .spi_miso_o(spi_miso), .addr_o(addr_o), .write_data_o(write_data_o),
        .write_en_o(write_en_o), .read_en_o(read_en_o), .read_data_i(read_data),
        .busy_o(busy_o)
    );

    function automatic logic [7:0] reg_model(input logic [6:0] a);
        if (model_sel == 0) return (a == 7'd3) ? 8'h3C : 8'hFF;
        return {1'b0, a} + 8'h40;
    endfunction

    // Register map model: data appears two cycles after addr/read_en.
    logic [7:0] rd_pipe = 8'h00;
    always @(posedge clk_i) begin
        rd_pipe   <= read_en_o ? reg_model(addr_o) : 8'h00;
        read_data <= rd_pipe;
    end

    // Write-strobe logger: one entry per write_en_o pulse.
    int         wl_cnt = 0;
    logic [6:0] wl_addr[16];
    logic [7:0] wl_data[16];
    int         wl_len[16];
    bit         wl_stable[16];
    int         run_len = 0;
    logic [6:0] run_addr;
    logic [7:0] run_data;
    bit         run_stable;
    logic       wen_prev = 1'b0;

    always @(negedge clk_i) begin
        if (write_en_o === 1'b1) begin
            if (!wen_prev) begin
                run_len = 1; run_addr = addr_o; run_data = write_data_o; run_stable = 1'b1;
            end else begin
                run_len++;
                if (addr_o !== run_addr || write_data_o !== run_data) run_stable = 1'b0;
            end
        end else if (wen_prev && wl_cnt < 16) begin
            wl_addr[wl_cnt] = run_addr; wl_data[wl_cnt] = run_data;
            wl_len[wl_cnt] = run_len; wl_stable[wl_cnt] = run_stable;
            wl_cnt++;
        end
        wen_prev = (write_en_o === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            repeat (HALF) @(negedge clk_i);
            spi_sclk = 1'b1;
            rx = {rx[6:0], spi_miso};
            repeat (HALF) @(negedge clk_i);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk_i);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk_i);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk_i);
    endtask

    task automatic check_write(input string name, input int idx, input logic [6:0] ea,
                               input logic [7:0] ed);
        n_checks++;
        if (wl_addr[idx] !== ea || wl_data[idx] !== ed || wl_len[idx] !== 4 || !wl_stable[idx]) begin
            n_fail++;
            $display("FAIL %s: addr=%0d data=%h len=%0d stable=%0d, expected addr=%0d data=%h len=4 stable=1",
                     name, wl_addr[idx], wl_data[idx], wl_len[idx], wl_stable[idx], ea, ed);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk_i);
        n_checks++;
        if ({spi_miso, addr_o, write_data_o, write_en_o, read_en_o, busy_o} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: miso=%b addr=%h wdata=%h wen=%b ren=%b busy=%b, expected all 0",
                     spi_miso, addr_o, write_data_o, write_en_o, read_en_o, busy_o);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_single_write();
        logic [7:0] rx;
        int base = wl_cnt;
        cs_begin();
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'hA5, 8, rx);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL single_write_busy_in_frame: got %b expected 1", busy_o);
        end
        cs_end();
        n_checks++;
        if (wl_cnt !== base + 1) begin
            n_fail++; $display("FAIL single_write_count: got %0d expected %0d", wl_cnt - base, 1);
        end else check_write("single_write", base, 7'd5, 8'hA5);
        n_checks++;
        if (addr_o !== 7'd6 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL single_write_after: addr=%0d busy=%b expected addr=6 busy=0", addr_o, busy_o);
        end
    endtask

    task automatic test_single_read();
        logic [7:0] rx;
        model_sel = 0;
        cs_begin();
        spi_xfer(8'h83, 8, rx);
        n_checks++;
        if (read_en_o !== 1'b1 || addr_o !== 7'd3) begin
            n_fail++; $display("FAIL single_read_cmd: ren=%b addr=%0d expected ren=1 addr=3", read_en_o, addr_o);
        end
        spi_xfer(8'h00, 8, rx);
        n_checks++;
        if (rx !== 8'h3C) begin
            n_fail++; $display("FAIL single_read_data: got %h expected 3c", rx);
        end
        cs_end();
        n_checks++;
        if (read_en_o !== 1'b0 || spi_miso !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL single_read_end: ren=%b miso=%b busy=%b expected 0 0 0", read_en_o, spi_miso, busy_o);
        end
    endtask

    task automatic test_burst_write();
        logic [7:0] rx;
        int base = wl_cnt;
        cs_begin();
        spi_xfer(8'h7E, 8, rx);
        spi_xfer(8'h11, 8, rx);
        spi_xfer(8'h22, 8, rx);
        spi_xfer(8'h33, 8, rx);
        cs_end();
        n_checks++;
        if (wl_cnt !== base + 3) begin
            n_fail++; $display("FAIL burst_write_count: got %0d expected 3", wl_cnt - base);
        end else begin
            check_write("burst_write_0", base,     7'd126, 8'h11);
            check_write("burst_write_1", base + 1, 7'd127, 8'h22);
            check_write("burst_write_wrap", base + 2, 7'd0, 8'h33);
        end
        n_checks++;
        if (addr_o !== 7'd1) begin
            n_fail++; $display("FAIL burst_write_addr_after: got %0d expected 1", addr_o);
        end
    endtask

    task automatic test_burst_read();
        logic [7:0] rx;
        logic [7:0] exp_b[3] = '{8'h4A, 8'h4B, 8'h4C};
        model_sel = 1;
        cs_begin();
        spi_xfer(8'h8A, 8, rx);
        for (int b = 0; b < 3; b++) begin
            spi_xfer(8'h00, 8, rx);
            n_checks++;
            if (rx !== exp_b[b]) begin
                n_fail++; $display("FAIL burst_read_byte%0d: got %h expected %h", b, rx, exp_b[b]);
            end
        end
        cs_end();
        n_checks++;
        if (read_en_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL burst_read_end: ren=%b busy=%b expected 0 0", read_en_o, busy_o);
        end
    endtask

    task automatic test_abort_partial();
        logic [7:0] rx;
        int base = wl_cnt;
        cs_begin();
        spi_xfer(8'h10, 8, rx);
        spi_xfer(8'hF0, 4, rx);
        repeat (HALF) @(negedge clk_i);
        spi_cs_n = 1'b1;
        repeat (20) @(negedge clk_i);
        n_checks++;
        if (wl_cnt !== base || busy_o !== 1'b0 || addr_o !== 7'h10) begin
            n_fail++; $display("FAIL abort_partial: writes=%0d busy=%b addr=%h expected 0 0 10",
                               wl_cnt - base, busy_o, addr_o);
        end
        // A following frame must start from a clean bit count.
        cs_begin();
        spi_xfer(8'h10, 8, rx);
        spi_xfer(8'h5A, 8, rx);
        cs_end();
        n_checks++;
        if (wl_cnt !== base + 1) begin
            n_fail++; $display("FAIL abort_partial_next_count: got %0d expected 1", wl_cnt - base);
        end else check_write("abort_partial_next", base, 7'h10, 8'h5A);
    endtask

    task automatic test_abort_pulse();
        logic [7:0] rx;
        int base = wl_cnt;
        int waited = 0;
        cs_begin();
        spi_xfer(8'h20, 8, rx);
        spi_xfer(8'hC3, 7, rx);
        spi_mosi = 1'b1;
        repeat (HALF) @(negedge clk_i);
        spi_sclk = 1'b1;
        while (write_en_o !== 1'b1 && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        n_checks++;
        if (write_en_o !== 1'b1) begin
            n_fail++; $display("FAIL abort_pulse_wen_timeout: wen=%b after %0d cycles expected 1", write_en_o, waited);
        end
        // Raised as the strobe starts; the synchronized rise lands inside the pulse.
        spi_cs_n = 1'b1;
        repeat (HALF) @(negedge clk_i);
        spi_sclk = 1'b0;
        repeat (8) @(negedge clk_i);
        n_checks++;
        if (wl_cnt !== base + 1) begin
            n_fail++; $display("FAIL abort_pulse_count: got %0d expected 1", wl_cnt - base);
        end else check_write("abort_pulse", base, 7'h20, 8'hC3);
        n_checks++;
        if (busy_o !== 1'b0 || write_en_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_pulse_idle: busy=%b wen=%b expected 0 0", busy_o, write_en_o);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        model_sel = 0;
        cs_begin();
        spi_xfer(8'h83, 8, rx);
        spi_xfer(8'h00, 3, rx);
        rst_n = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({spi_miso, addr_o, write_data_o, write_en_o, read_en_o, busy_o} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid_read_outputs: miso=%b addr=%h wdata=%h wen=%b ren=%b busy=%b, expected all 0",
                     spi_miso, addr_o, write_data_o, write_en_o, read_en_o, busy_o);
        end
        rst_n = 1'b1;
        spi_xfer(8'h00, 5, rx);
        spi_xfer(8'h83, 8, rx);
        n_checks++;
        if (busy_o !== 1'b0 || read_en_o !== 1'b0 || addr_o !== 7'd0) begin
            n_fail++; $display("FAIL reset_mid_read_quiet: busy=%b ren=%b addr=%0d expected 0 0 0",
                               busy_o, read_en_o, addr_o);
        end
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk_i);
        cs_begin();
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_read_restart_busy: got %b expected 1", busy_o);
        end
        spi_xfer(8'h83, 8, rx);
        spi_xfer(8'h00, 8, rx);
        n_checks++;
        if (rx !== 8'h3C) begin
            n_fail++; $display("FAIL reset_mid_read_restart_data: got %h expected 3c", rx);
        end
        cs_end();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_write();
        test_burst_read();
        test_abort_partial();
        test_abort_pulse();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
